// File: rtl/display_scan_ctrl_pkg.sv
// ============================================================================
//  Module      : display_scan_ctrl_pkg
//  Description : Shared constants and helpers for the 4-digit display scanner.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package display_scan_ctrl_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;   // all segments and dp off (active-low)
    localparam logic [3:0] AN_OFF     = 4'b1111; // all anodes off (active-low)
    localparam int         NUM_DIGITS = 4;

    // Counter width for a modulus; never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_ctrl_seven_segment.sv
// ============================================================================
//  Module      : seven_segment
//  Description : BCD nibble to common-anode 7-segment pattern {dp,g..a},
//                active-low. dp is always off here; 10..15 decode to blank.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_segment
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    // Pure lookup; anything outside 0..9 shows nothing.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ============================================================================
//  Module      : display_scan_ctrl
//  Description : Time-multiplexes four BCD digits onto a common-anode 4-digit
//                7-segment display through one shared decoder. Digit value,
//                dp and blink bit are captured at each slot boundary so seg
//                and an always belong to the same slot.
//  Config      : SEG_BLINK_EN - builds the blink counter/phase; without it
//                blink_mask is ignored and only enable blanks.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blink_mask,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic [1:0]  scan_idx
);

    localparam int              c_SW        = cnt_width(REFRESH_DIV);
    localparam logic [c_SW-1:0] c_SLOT_LAST = c_SW'(REFRESH_DIV - 1);

    logic [c_SW-1:0] r_slot_cnt;
    logic            w_tick;
    logic            r_started;   // set once the first slot has been captured
    logic [1:0]      r_scan_idx;
    logic [1:0]      w_next_idx;
    logic [3:0]      r_nib;
    logic            r_dp;
    logic [7:0]      w_dec;
    logic            w_blank;

    assign w_tick     = (r_slot_cnt == c_SLOT_LAST);
    // The very first capture after reset shows digit 0 rather than skipping it.
    assign w_next_idx = r_started ? r_scan_idx + 2'd1 : 2'd0;
    assign scan_idx   = r_scan_idx;

    // Slot counter: free-running 0..REFRESH_DIV-1, independent of enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_slot_cnt <= '0;
        else if (w_tick) r_slot_cnt <= '0;
        else             r_slot_cnt <= r_slot_cnt + 1'b1;
    end

    // Advance the scan index and capture that digit's nibble and dp at the slot edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_started  <= 1'b0;
            r_scan_idx <= 2'd0;
            r_nib      <= 4'd0;
            r_dp       <= 1'b0;
        end else if (w_tick) begin
            r_started  <= 1'b1;
            r_scan_idx <= w_next_idx;
            r_nib      <= digits[{w_next_idx, 2'b00} +: 4];
            r_dp       <= dp_mask[w_next_idx];
        end
    end

`ifdef SEG_BLINK_EN
    localparam int              c_BW         = cnt_width(BLINK_DIV);
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_DIV - 1);

    logic [c_BW-1:0] r_blink_cnt;
    logic            r_blink_on;
    logic            r_blink_bit;

    // Blink timebase counts slot ticks; phase flips each time it wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_blink_bit <= 1'b0;
        end else if (w_tick) begin
            r_blink_bit <= blink_mask[w_next_idx];
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_blank = !r_started || !enable || (r_blink_bit && !r_blink_on);
`else
    logic w_blink_unused;

    assign w_blink_unused = ^{blink_mask, BLINK_DIV[0]};
    assign w_blank        = !r_started || !enable;
`endif

    seven_segment u_dec (
        .digit (r_nib),
        .seg   (w_dec)
    );

    // Register seg and an together from the same captured slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else if (w_blank) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else begin
            seg <= {w_dec[7] & ~r_dp, w_dec[6:0]};
            an  <= ~(4'b0001 << r_scan_idx);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ============================================================================
//  Module      : tb_display_scan_ctrl
//  Description : Directed self-checking bench for display_scan_ctrl with
//                REFRESH_DIV=4, BLINK_DIV=2. Expectations are hand-computed.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] digits = 16'h1234;
    logic [3:0]  dp_mask = 4'b0000;
    logic [3:0]  blink_mask = 4'b0000;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [1:0]  scan_idx;

    int n_checks = 0;
    int n_errs   = 0;

    display_scan_ctrl #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .seg        (seg),
        .an         (an),
        .scan_idx   (scan_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance n rising edges, then sample 1ns later.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_an  [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [7:0] exp_seg [4] = '{8'hB0, 8'hA4, 8'hF9, 8'h99};
    logic [1:0] exp_idx [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        // Power-up reset, checked asynchronously
        #1 rst = 1'b1;
        #1;
        check("rst_an",  an,  4'hF);
        check("rst_seg", seg, 8'hFF);
        check("rst_idx", scan_idx, 2'd0);
        #1 rst = 1'b0;
        step(6);
        check("run_an", an, 4'b1110);

        // Mid-slot reset: immediate return to reset values
        rst = 1'b1;
        #1;
        check("mid_rst_an",  an,  4'hF);
        check("mid_rst_seg", seg, 8'hFF);
        check("mid_rst_idx", scan_idx, 2'd0);
        rst = 1'b0;
        step(4);
        check("pre_first_an", an, 4'hF);
        step(1);
        check("first_an",  an,  4'b1110);
        check("first_seg", seg, 8'h99);
        check("first_idx", scan_idx, 2'd0);

        // Scan through 3,2,1 and wrap to digit 0
        for (int i = 0; i < 4; i++) begin
            step(4);
            check($sformatf("scan_an%0d", i),  an,  exp_an[i]);
            check($sformatf("scan_seg%0d", i), seg, exp_seg[i]);
            check($sformatf("scan_idx%0d", i), scan_idx, exp_idx[i]);
        end

        // Mid-slot data change must not disturb the current slot
        digits = 16'h5678;
        step(3);
        check("hold_an",  an,  4'b1110);
        check("hold_seg", seg, 8'h99);
        step(1);
        check("new_an",  an,  4'b1101);
        check("new_seg", seg, 8'hF8);

        // Invalid nibble with dp: dp only
        dp_mask = 4'b0100;
        digits  = 16'h5A78;
        step(4);
        check("dp_an",  an,  4'b1011);
        check("dp_seg", seg, 8'h7F);
        step(4);
        check("d3_an",  an,  4'b0111);
        check("d3_seg", seg, 8'h92);

        // Disable for 10 clocks; scanning keeps going underneath
        enable = 1'b0;
        step(1);
        check("dis_an",  an,  4'hF);
        check("dis_seg", seg, 8'hFF);
        step(9);
        check("dis_an_end", an, 4'hF);
        check("dis_idx",    scan_idx, 2'd1);
        enable = 1'b1;
        step(1);
        check("reen_an",  an,  4'b1101);
        check("reen_seg", seg, 8'hF8);
        check("reen_idx", scan_idx, 2'd2);
        step(1);
        check("reen2_an",  an,  4'b1011);
        check("reen2_seg", seg, 8'h7F);

        // Blink: digit0 always falls in the on phase, digit1 in the off phase
        dp_mask    = 4'b0000;
        digits     = 16'h1234;
        blink_mask = 4'b0011;
        for (int r = 0; r < 2; r++) begin
            step(r == 0 ? 8 : 12);
            check($sformatf("blk_d0_an%0d", r),  an,  4'b1110);
            check($sformatf("blk_d0_seg%0d", r), seg, 8'h99);
            step(4);
`ifdef SEG_BLINK_EN
            check($sformatf("blk_d1_an%0d", r),  an,  4'hF);
            check($sformatf("blk_d1_seg%0d", r), seg, 8'hFF);
`else
            check($sformatf("blk_d1_an%0d", r),  an,  4'b1101);
            check($sformatf("blk_d1_seg%0d", r), seg, 8'hB0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
